// File: rtl/aes_dec_round_ctrl.sv
// Sequencer for an iterative AES-128 decryption datapath.
// Runs key expansion on a new key, then the inverse rounds NR..0.
module aes_dec_round_ctrl #(
  parameter int NR        = 10,
  parameter int KEY_STEPS = 10,
  parameter int IDX_W     = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             KEY_NEW,
  output logic             LOAD_EN,
  output logic             KX_EN,
  output logic [IDX_W-1:0] KX_ROUND,
  output logic             RND_EN,
  output logic [1:0]       RND_MODE,
  output logic [IDX_W-1:0] RND_IDX,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             BUSY,
  output logic             KEY_CACHED
);

  typedef enum logic [2:0] {
    IDLE, KEXP, INIT, ROUND, FINAL, DONE
  } state_t;

  localparam logic [IDX_W-1:0] NR_I = IDX_W'(NR);
  localparam logic [IDX_W-1:0] KS_I = IDX_W'(KEY_STEPS);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             cached_q, cached_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cached_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cached_q <= cached_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cached_d = cached_q;
    unique case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          if (KEY_NEW || !cached_q) begin
            state_d  = KEXP;
            cnt_d    = ONE;
            cached_d = 1'b0;
          end else begin
            state_d = INIT;
          end
        end
      end
      KEXP: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == KS_I) begin
          cached_d = 1'b1;
          cnt_d    = '0;
          state_d  = INIT;
        end
      end
      INIT: begin
        cnt_d   = NR_I - ONE;
        state_d = (NR == 1) ? FINAL : ROUND;
      end
      ROUND: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) state_d = FINAL;
      end
      FINAL: state_d = DONE;
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic st_idle, st_kexp, st_init;
  logic st_round, st_final, st_done;

  assign st_idle  = (state_q == IDLE);
  assign st_kexp  = (state_q == KEXP);
  assign st_init  = (state_q == INIT);
  assign st_round = (state_q == ROUND);
  assign st_final = (state_q == FINAL);
  assign st_done  = (state_q == DONE);

  always_comb begin
    IN_READY  = 1'b0;
    KX_EN     = 1'b0;
    KX_ROUND  = '0;
    RND_EN    = 1'b0;
    RND_MODE  = 2'b00;
    RND_IDX   = '0;
    OUT_VALID = 1'b0;
    unique case (1'b1)
      st_idle:  IN_READY = 1'b1;
      st_kexp: begin
        KX_EN    = 1'b1;
        KX_ROUND = cnt_q;
      end
      st_init: begin
        RND_EN  = 1'b1;
        RND_IDX = NR_I;
      end
      st_round: begin
        RND_EN   = 1'b1;
        RND_MODE = 2'b01;
        RND_IDX  = cnt_q;
      end
      st_final: begin
        RND_EN   = 1'b1;
        RND_MODE = 2'b10;
      end
      st_done:  OUT_VALID = 1'b1;
      default:  IN_READY = 1'b0;
    endcase
  end

  // Only the input handshake strobe is combinational.
  assign LOAD_EN    = IN_VALID & IN_READY;
  assign BUSY       = ~st_idle;
  assign KEY_CACHED = cached_q;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Self-checking bench for aes_dec_round_ctrl.
// Queue-based job model plus directed literal checks.
module tb_aes_dec_round_ctrl;

  localparam int NR = 10;
  localparam int KS = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, key_new = 1'b0, out_ready = 1'b0;
  logic       in_ready, load_en, kx_en, rnd_en, out_valid, busy, key_cached;
  logic [3:0] kx_round, rnd_idx;
  logic [1:0] rnd_mode;

  logic       in_valid1 = 1'b0, key_new1 = 1'b0, out_ready1 = 1'b0;
  logic       in_ready1, load_en1, kx_en1, rnd_en1, out_valid1, busy1, key_cached1;
  logic [3:0] kx_round1, rnd_idx1;
  logic [1:0] rnd_mode1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_dec_round_ctrl #(.NR(NR), .KEY_STEPS(KS), .IDX_W(4)) dut (
    .CLK(clk), .RST_N(rst_n),
    .IN_VALID(in_valid), .IN_READY(in_ready), .KEY_NEW(key_new),
    .LOAD_EN(load_en), .KX_EN(kx_en), .KX_ROUND(kx_round),
    .RND_EN(rnd_en), .RND_MODE(rnd_mode), .RND_IDX(rnd_idx),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .BUSY(busy), .KEY_CACHED(key_cached)
  );

  aes_dec_round_ctrl #(.NR(1), .KEY_STEPS(1), .IDX_W(4)) dut1 (
    .CLK(clk), .RST_N(rst_n),
    .IN_VALID(in_valid1), .IN_READY(in_ready1), .KEY_NEW(key_new1),
    .LOAD_EN(load_en1), .KX_EN(kx_en1), .KX_ROUND(kx_round1),
    .RND_EN(rnd_en1), .RND_MODE(rnd_mode1), .RND_IDX(rnd_idx1),
    .OUT_VALID(out_valid1), .OUT_READY(out_ready1),
    .BUSY(busy1), .KEY_CACHED(key_cached1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One queue entry per busy cycle of a job, built from the round schedule.
  typedef struct packed {
    logic       kx;
    logic [3:0] kxr;
    logic       rnd;
    logic [1:0] mode;
    logic [3:0] idx;
    logic       setc;
  } step_t;

  step_t mq[$];
  int    m_phase = 0;
  bit    m_cached = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_phase  = 0;
      m_cached = 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          if (key_new || !m_cached) begin
            m_cached = 1'b0;
            for (int k = 1; k <= KS; k++)
              mq.push_back('{1'b1, 4'(k), 1'b0, 2'd0, 4'd0, (k == KS)});
          end
          mq.push_back('{1'b0, 4'd0, 1'b1, 2'd0, 4'(NR), 1'b0});
          for (int r = NR - 1; r >= 1; r--)
            mq.push_back('{1'b0, 4'd0, 1'b1, 2'd1, 4'(r), 1'b0});
          mq.push_back('{1'b0, 4'd0, 1'b1, 2'd2, 4'd0, 1'b0});
          m_phase = 1;
        end
        1: begin
          step_t s;
          s = mq.pop_front();
          if (s.setc) m_cached = 1'b1;
          if (mq.size() == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  initial forever begin
    logic [16:0] e, a;
    step_t       s;
    @(negedge clk);
    if (rst_n) begin
      s = '0;
      if (m_phase == 1) s = mq[0];
      e = {m_phase == 0, in_valid && m_phase == 0, s.kx, s.kxr,
           s.rnd, s.mode, s.idx, m_phase == 2, m_phase != 0, m_cached};
      a = {in_ready, load_en, kx_en, kx_round, rnd_en, rnd_mode,
           rnd_idx, out_valid, busy, key_cached};
      chk("cycle_outputs", int'(a), int'(e));
    end
  end

  task automatic run_job(input bit kn, input int hold, input bit early,
                         input bit tog, output int lat, output int nkx,
                         output int nrnd, output int nov, output int nld);
    int hs;
    int waited;
    lat = -1; nkx = 0; nrnd = 0; nov = 0; nld = 0; waited = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    key_new  = kn;
    @(negedge clk); #1;
    chk("load_en_pulse", int'(load_en), 1);
    @(posedge clk); #1;
    hs = cyc;
    in_valid  = 1'b0;
    key_new   = 1'b0;
    out_ready = early;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (tog && lat < 0) in_valid = i[0];
      nkx  += int'(kx_en);
      nrnd += int'(rnd_en);
      nld  += int'(load_en);
      if (out_valid) begin
        if (lat < 0) lat = cyc - hs;
        nov++;
        in_valid = 1'b0;
        if (waited >= hold) out_ready = 1'b1;
        else begin
          waited++;
          chk("done_in_ready", int'(in_ready), 0);
        end
      end
      if (!busy && lat >= 0) break;
    end
    out_ready = 1'b0;
    chk("job_completed", int'(lat >= 0), 1);
  endtask

  int lat, nkx, nrnd, nov, nld;
  bit found;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_key_cached", int'(key_cached), 0);
    chk("rst_enables", int'({kx_en, rnd_en, out_valid, rnd_mode}), 0);
    rst_n = 1'b1;

    run_job(1'b1, 0, 1'b0, 1'b0, lat, nkx, nrnd, nov, nld);
    chk("new_key_latency", lat, 21);
    chk("new_key_kx_pulses", nkx, 10);
    chk("new_key_rnd_pulses", nrnd, 11);
    chk("new_key_out_cycles", nov, 1);
    chk("key_cached_after", int'(key_cached), 1);

    run_job(1'b0, 0, 1'b0, 1'b0, lat, nkx, nrnd, nov, nld);
    chk("cached_latency", lat, 11);
    chk("cached_kx_pulses", nkx, 0);
    chk("cached_key_cached", int'(key_cached), 1);

    run_job(1'b0, 5, 1'b0, 1'b0, lat, nkx, nrnd, nov, nld);
    chk("stall_out_cycles", nov, 6);
    chk("stall_busy_after", int'(busy), 0);

    run_job(1'b0, 0, 1'b1, 1'b0, lat, nkx, nrnd, nov, nld);
    chk("early_ready_out_cycles", nov, 1);
    chk("early_ready_latency", lat, 11);

    run_job(1'b0, 0, 1'b0, 1'b1, lat, nkx, nrnd, nov, nld);
    chk("toggle_no_load", nld, 0);
    chk("toggle_rnd_pulses", nrnd, 11);
    chk("toggle_latency", lat, 11);

    @(posedge clk); #1;
    in_valid = 1'b1;
    key_new  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    key_new  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #1;
      if (kx_en && kx_round == 4'd4) found = 1'b1;
    end
    chk("reached_kx4", int'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_key_cached", int'(key_cached), 0);
    chk("midrst_kx", int'({kx_en, kx_round}), 0);
    #2;
    rst_n = 1'b1;

    run_job(1'b0, 0, 1'b0, 1'b0, lat, nkx, nrnd, nov, nld);
    chk("post_rst_kx_pulses", nkx, 10);
    chk("post_rst_latency", lat, 21);

    @(posedge clk); #1;
    in_valid1 = 1'b1;
    @(negedge clk); #1;
    chk("nr1_load", int'(load_en1), 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(negedge clk); #1;
    chk("nr1_kx", int'({kx_en1, kx_round1, rnd_en1}), 'b1_0001_0);
    @(negedge clk); #1;
    chk("nr1_init", int'({kx_en1, rnd_en1, rnd_mode1, rnd_idx1}), 'b0_1_00_0001);
    @(negedge clk); #1;
    chk("nr1_final", int'({kx_en1, rnd_en1, rnd_mode1, rnd_idx1}), 'b0_1_10_0000);
    @(negedge clk); #1;
    chk("nr1_out_valid", int'(out_valid1), 1);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("nr1_idle", int'(busy1), 0);
    chk("nr1_key_cached", int'(key_cached1), 1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_dec_round_ctrl.md
Name: aes_dec_round_ctrl

Overview:
Iterative sequencer for an AES-128 decryption datapath built around one shared inverse-round unit and one key-expansion step unit. It accepts a ciphertext/key job through a valid/ready handshake and schedules the key-expansion steps into the round-key store. It then schedules the initial AddRoundKey, the NR-1 full inverse rounds and the final inverse round, and presents the result through a valid/ready output handshake. It caches the expanded key schedule so that back-to-back blocks under the same key skip expansion.

Parameters:
NR, 10, number of cipher rounds; round index runs NR down to 0.
KEY_STEPS, 10, key-expansion cycles per new key; writes round keys 1..KEY_STEPS.
IDX_W, 4, width of round/key index outputs; must satisfy 2^IDX_W > max(NR, KEY_STEPS).

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
IN_VALID  input  1  job request; data/key buses held stable by source while high
IN_READY  output  1  controller can accept a job
KEY_NEW  input  1  sampled at input handshake; 1 = key differs from cached schedule
LOAD_EN  output  1  datapath captures ciphertext and cipher key (round key 0) this edge
KX_EN  output  1  key-expansion step enable
KX_ROUND  output  IDX_W  round key being produced/written (1..KEY_STEPS)
RND_EN  output  1  inverse-round unit enable; state register updates this edge
RND_MODE  output  2  00 initial AddRoundKey, 01 full inverse round, 10 final round (no InvMixColumns)
RND_IDX  output  IDX_W  round-key read address for the current round operation
OUT_VALID  output  1  decrypted block valid on datapath output
OUT_READY  input  1  sink accepts result
BUSY  output  1  any state other than IDLE
KEY_CACHED  output  1  round-key store holds a complete schedule

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; key_cached=0; counters=0. Outputs: IN_READY=1, all enables 0, indices 0, RND_MODE=00, OUT_VALID=0, BUSY=0, KEY_CACHED=0. Reset mid-job abandons the job with no output and clears key_cached.
- All outputs except LOAD_EN are Moore decodes of registered state/counters. LOAD_EN = IN_VALID & IN_READY (combinational).
- States: IDLE, KEXP, INIT, ROUND, FINAL, DONE.
- IDLE: IN_READY=1. On handshake, if KEY_NEW=1 or key_cached=0, go to KEXP, clear key_cached and set counter to 1. Otherwise go to INIT.
- KEXP: KX_EN=1, KX_ROUND=counter. The counter increments each cycle. After the cycle with KX_ROUND=KEY_STEPS, set key_cached=1 and go to INIT.
- INIT: RND_EN=1, RND_MODE=00, RND_IDX=NR, for one cycle. Go to ROUND, setting counter to NR-1.
- ROUND: RND_EN=1, RND_MODE=01, RND_IDX=counter. The counter decrements each cycle. After the cycle with RND_IDX=1, go to FINAL. If NR=1, INIT goes directly to FINAL.
- FINAL: RND_EN=1, RND_MODE=10, RND_IDX=0, for one cycle. Go to DONE.
- DONE: OUT_VALID=1 and held until OUT_READY=1, which completes the handshake at that edge and returns to IDLE. IN_READY=0 in DONE, so there is no same-cycle re-accept and one bubble cycle is guaranteed.
- Latency from the input-handshake edge to OUT_VALID high: KEY_STEPS+NR+1 cycles with expansion (21 at defaults); NR+1 cycles with the cached key (11).
- IN_VALID is ignored outside IDLE. KEY_NEW is sampled only at the handshake edge.
- OUT_READY is ignored outside DONE. OUT_READY held high in advance still causes exactly one DONE cycle.
- RND_EN and KX_EN are never high together. Exactly NR+1 RND_EN pulses and either 0 or KEY_STEPS KX_EN pulses occur per job.
- BUSY=1 in every state except IDLE. KEY_CACHED mirrors key_cached.

Test Plan:
- Reset, then one job with KEY_NEW=1 at defaults (ciphertext 3925841D02DC09FBDC118597196A0B32, key 2B7E151628AED2A6ABF7158809CF4F3C) -> expected behaviour:
  - LOAD_EN one pulse.
  - KX_ROUND runs 1..10 on consecutive cycles.
  - RND_IDX/MODE sequence: 10/00, 9..1/01, 0/10.
  - OUT_VALID rises 21 cycles after the handshake.
  - With the datapath attached, the output equals 3243F6A8885A308D313198A2E0370734.
- Second job with KEY_NEW=0 directly after the first -> no KX_EN pulses; OUT_VALID 11 cycles after the handshake; KEY_CACHED stays 1.
- KEY_NEW=0 immediately after reset -> expansion still runs (10 KX_EN pulses), latency 21.
- OUT_READY held low for 5 cycles in DONE -> OUT_VALID stays 1 and IN_READY stays 0 throughout; returns to IDLE on the edge where OUT_READY=1.
- RST_N asserted during KEXP at KX_ROUND=4 -> all outputs take reset values immediately; KEY_CACHED=0; the next KEY_NEW=0 job performs full expansion.
- IN_VALID toggled while BUSY=1 -> no LOAD_EN, no sequence disturbance. Separately, parameter NR=1, KEY_STEPS=1 -> pulse sequence KX(1), INIT(idx 1), FINAL(idx 0), latency 3.
